cp0_exc_reg: RTL and testbench

Parametrised coprocessor-0 register file with precise-exception support for the OpenMIPS core. It holds Count/Compare/Status/Cause/EPC/PRId/Config (and optionally BadVAddr), records exception state when the MEM stage reports an exception, clears it on `eret`, and produces the masked interrupt-pending signal used by the exception logic. It sits beside MEM/WB: mtc0 writes and exception reports arrive from MEM/WB, and mfc0 reads are served combinationally to EX.

---
 rtl/cp0_exc_reg.sv | 155 +++++++++++++++
 tb/tb_cp0_exc_reg.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_reg.sv
// Coprocessor-0 register file: Count/Compare/Status/Cause/EPC/PRId/Config with exception recording.
// Optional BadVAddr register (reg 8) is built only when CP0_BADVADDR_EN is defined.
module cp0_exc_reg #(
  parameter int          INT_NUM      = 6,
  parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INT_NUM-1:0] int_i,
  input  logic               we_i,
  input  logic [4:0]         waddr_i,
  input  logic [31:0]        data_i,
  input  logic [4:0]         raddr_i,
  input  logic               exc_valid_i,
  input  logic [4:0]         exc_code_i,
  input  logic [31:0]        exc_pc_i,
  input  logic               exc_bd_i,
  input  logic [31:0]        exc_badvaddr_i,
  input  logic               eret_i,
  output logic [31:0]        data_o,
  output logic [31:0]        count_o,
  output logic [31:0]        compare_o,
  output logic [31:0]        status_o,
  output logic [31:0]        cause_o,
  output logic [31:0]        epc_o,
  output logic               timer_int_o,
  output logic               int_pending_o
);

  localparam logic [4:0]  ADDR_BADVADDR = 5'd8;
  localparam logic [4:0]  ADDR_COUNT    = 5'd9;
  localparam logic [4:0]  ADDR_COMPARE  = 5'd11;
  localparam logic [4:0]  ADDR_STATUS   = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE    = 5'd13;
  localparam logic [4:0]  ADDR_EPC      = 5'd14;
  localparam logic [4:0]  ADDR_PRID     = 5'd15;
  localparam logic [4:0]  ADDR_CONFIG   = 5'd16;
  localparam logic [31:0] STATUS_MASK   = 32'hF000FF03;
  localparam logic [31:0] STATUS_RESET  = 32'h10000000;

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [31:0] r_status;
  logic [31:0] r_epc;
  logic        r_timer;
  logic        r_cause_bd;
  logic [4:0]  r_exc_code;
  logic [1:0]  r_ip_sw;
  logic [5:0]  r_int;

  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic        w_wr_cause;
  logic        w_wr_epc;
  logic        w_exl;
  logic        w_first_exc;
  logic [5:0]  w_int_ext;
  logic [31:0] w_status_next;
  logic [31:0] w_rdata;
  logic [31:0] w_badvaddr;

  assign w_wr_count   = we_i && (waddr_i == ADDR_COUNT);
  assign w_wr_compare = we_i && (waddr_i == ADDR_COMPARE);
  assign w_wr_status  = we_i && (waddr_i == ADDR_STATUS);
  assign w_wr_cause   = we_i && (waddr_i == ADDR_CAUSE);
  assign w_wr_epc     = we_i && (waddr_i == ADDR_EPC);
  assign w_exl        = r_status[1];
  // Only the first exception of a nest captures EPC/BD; nested ones just update ExcCode.
  assign w_first_exc  = exc_valid_i && !w_exl;

  always_comb begin
    w_int_ext = '0;
    for (int i = 0; i < INT_NUM; i++) w_int_ext[i] = int_i[i];
  end

  // Later assignments win: mtc0, then eret, then exception.
  always_comb begin
    w_status_next = r_status;
    if (w_wr_status) w_status_next = data_i & STATUS_MASK;
    if (eret_i)      w_status_next[1] = 1'b0;
    if (exc_valid_i) w_status_next[1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_compare  <= '0;
      r_status   <= STATUS_RESET;
      r_epc      <= '0;
      r_timer    <= 1'b0;
      r_cause_bd <= 1'b0;
      r_exc_code <= '0;
      r_ip_sw    <= '0;
      r_int      <= '0;
    end else begin
      r_count  <= w_wr_count ? data_i : r_count + 32'd1;
      r_status <= w_status_next;
      r_int    <= w_int_ext;
      if (w_wr_compare) r_compare <= data_i;
      if (w_wr_compare) r_timer <= 1'b0;
      else if ((r_compare != '0) && (r_count == r_compare)) r_timer <= 1'b1;
      if (w_wr_cause) r_ip_sw <= data_i[9:8];
      if (exc_valid_i) r_exc_code <= exc_code_i;
      if (w_first_exc) begin
        r_cause_bd <= exc_bd_i;
        r_epc      <= exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
      end else if (w_wr_epc) begin
        r_epc <= data_i;
      end
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] r_badvaddr;
  always_ff @(posedge clk) begin
    if (rst) r_badvaddr <= '0;
    else if (exc_valid_i && ((exc_code_i == 5'd4) || (exc_code_i == 5'd5)))
      r_badvaddr <= exc_badvaddr_i;
  end
  assign w_badvaddr = r_badvaddr;
`else
  logic w_unused_badvaddr;
  assign w_unused_badvaddr = ^exc_badvaddr_i;
  assign w_badvaddr = '0;
`endif

  assign count_o     = r_count;
  assign compare_o   = r_compare;
  assign status_o    = r_status;
  assign epc_o       = r_epc;
  assign timer_int_o = r_timer;
  assign cause_o     = {r_cause_bd, 15'b0, r_int[5] | r_timer, r_int[4:0],
                        r_ip_sw, 1'b0, r_exc_code, 2'b00};
  assign int_pending_o = r_status[0] && !r_status[1] && |(cause_o[15:8] & r_status[15:8]);

  always_comb begin
    w_rdata = '0;
    case (raddr_i)
      ADDR_BADVADDR: w_rdata = w_badvaddr;
      ADDR_COUNT:    w_rdata = r_count;
      ADDR_COMPARE:  w_rdata = r_compare;
      ADDR_STATUS:   w_rdata = r_status;
      ADDR_CAUSE:    w_rdata = cause_o;
      ADDR_EPC:      w_rdata = r_epc;
      ADDR_PRID:     w_rdata = PRID_VALUE;
      ADDR_CONFIG:   w_rdata = CONFIG_VALUE;
      default:       w_rdata = '0;
    endcase
  end

  assign data_o = rst ? '0 : w_rdata;

endmodule

// File: tb/tb_cp0_exc_reg.sv
// Randomized self-checking bench for cp0_exc_reg against a cycle-level reference model.
// Honours CP0_BADVADDR_EN the same way the design does.
module tb_cp0_exc_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic        exc_valid_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        exc_bd_i;
  logic [31:0] exc_badvaddr_i;
  logic        eret_i;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o;
  logic        timer_int_o, int_pending_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  cp0_exc_reg dut (
    .clk(clk), .rst(rst), .int_i(int_i), .we_i(we_i), .waddr_i(waddr_i),
    .data_i(data_i), .raddr_i(raddr_i), .exc_valid_i(exc_valid_i),
    .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i), .exc_bd_i(exc_bd_i),
    .exc_badvaddr_i(exc_badvaddr_i), .eret_i(eret_i), .data_o(data_o),
    .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .timer_int_o(timer_int_o),
    .int_pending_o(int_pending_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // reference model state: architectural fields, not the RTL's register layout
  logic [31:0] m_count, m_compare, m_status, m_epc, m_bva;
  logic        m_timer, m_bd;
  logic [4:0]  m_code;
  logic [1:0]  m_ipsw;
  logic [5:0]  m_int;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_cause();
    logic [5:0] ip_hw;
    ip_hw = m_int;
    if (m_timer) ip_hw = ip_hw | 6'b100000;
    return {m_bd, 15'b0, ip_hw, m_ipsw, 1'b0, m_code, 2'b00};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
`ifdef CP0_BADVADDR_EN
      5'd8:  return m_bva;
`endif
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause();
      5'd14: return m_epc;
      5'd15: return 32'h004C0102;
      5'd16: return 32'h00008000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_pending();
    logic [31:0] c;
    c = m_cause();
    return m_status[0] && !m_status[1] && ((c[15:8] & m_status[15:8]) != 8'h00);
  endfunction

  // apply one clock edge of architectural rules to the model
  task automatic model_step();
    logic [31:0] n_count, n_compare, n_status, n_epc, n_bva;
    logic        n_timer, n_bd;
    logic [4:0]  n_code;
    logic [1:0]  n_ipsw;
    logic        exl;
    if (rst) begin
      m_count = 0; m_compare = 0; m_status = 32'h10000000; m_epc = 0; m_bva = 0;
      m_timer = 0; m_bd = 0; m_code = 0; m_ipsw = 0; m_int = 0;
      return;
    end
    exl = m_status[1];
    n_count = m_count + 1; n_compare = m_compare; n_status = m_status; n_epc = m_epc;
    n_bva = m_bva; n_timer = m_timer; n_bd = m_bd; n_code = m_code; n_ipsw = m_ipsw;
    if (m_compare != 0 && m_count == m_compare) n_timer = 1;
    if (we_i) begin
      case (waddr_i)
        5'd9:  n_count = data_i;
        5'd11: begin n_compare = data_i; n_timer = 0; end
        5'd12: n_status = data_i & 32'hF000FF03;
        5'd13: n_ipsw = data_i[9:8];
        5'd14: n_epc = data_i;
        default: ;
      endcase
    end
    if (eret_i) n_status[1] = 0;
    if (exc_valid_i) begin
      n_code = exc_code_i;
      n_status[1] = 1;
      if (!exl) begin
        n_bd  = exc_bd_i;
        n_epc = exc_bd_i ? exc_pc_i - 4 : exc_pc_i;
      end
      if (exc_code_i == 4 || exc_code_i == 5) n_bva = exc_badvaddr_i;
    end
    m_count = n_count; m_compare = n_compare; m_status = n_status; m_epc = n_epc;
    m_bva = n_bva; m_timer = n_timer; m_bd = n_bd; m_code = n_code; m_ipsw = n_ipsw;
    m_int = int_i;
  endtask

  task automatic check_all();
    exp_q.push_back(rst ? 32'h0 : m_read(raddr_i));
    check("data_o", data_o, exp_q.pop_front());
    check("count", count_o, m_count);
    check("compare", compare_o, m_compare);
    check("status", status_o, m_status);
    check("cause", cause_o, m_cause());
    check("epc", epc_o, m_epc);
    check("timer", 32'(timer_int_o), 32'(m_timer));
    check("pending", 32'(int_pending_o), 32'(m_pending()));
  endtask

  // driver: one cycle with current inputs, then strobes drop
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    we_i = 0; exc_valid_i = 0; eret_i = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1; waddr_i = a; data_i = d;
    tick();
  endtask

  task automatic raise_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                           input logic [31:0] bva);
    exc_valid_i = 1; exc_code_i = code; exc_pc_i = pc; exc_bd_i = bd; exc_badvaddr_i = bva;
    tick();
  endtask

  initial begin
    int rise_at;
    logic [4:0] addr_tbl [9];
    addr_tbl = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
    rst = 1; int_i = 0; we_i = 0; waddr_i = 0; data_i = 0; raddr_i = 0;
    exc_valid_i = 0; exc_code_i = 0; exc_pc_i = 0; exc_bd_i = 0;
    exc_badvaddr_i = 0; eret_i = 0;
    tick(); tick();
    check("rst_status", status_o, 32'h10000000);
    rst = 0;

    // read every address after reset
    for (int a = 0; a < 32; a++) begin
      raddr_i = 5'(a);
      tick();
    end
    raddr_i = 15; #1 check("prid", data_o, 32'h004C0102);
    raddr_i = 16; #1 check("config", data_o, 32'h00008000);
    raddr_i = 8;  #1 check("badvaddr_rst", data_o, 32'h0);

    // timer
    mtc0(11, 20);
    mtc0(9, 10);
    rise_at = -1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (timer_int_o && rise_at < 0) rise_at = k;
    end
    check("timer_rise", 32'(rise_at), 32'd11);
    mtc0(11, 50);
    check("timer_clear", 32'(timer_int_o), 32'd0);

    // exceptions
    raddr_i = 14;
    raise_exc(8, 32'h100, 1, 0);
    check("epc_bd", epc_o, 32'hFC);
    check("cause_bd_code", cause_o & 32'h8000007C, 32'h80000020);
    check("exl_set", 32'(status_o[1]), 32'd1);
    raise_exc(12, 32'h200, 0, 0);
    check("epc_nested", epc_o, 32'hFC);
    check("code_nested", 32'(cause_o[6:2]), 32'd12);

    // interrupts and eret/exception collision
    mtc0(12, 32'h00000401);
    int_i = 6'b000001;
    tick();
    check("pend_on", 32'(int_pending_o), 32'd1);
    eret_i = 1;
    raise_exc(0, 32'h300, 0, 0);
    check("exl_exc_wins", 32'(status_o[1]), 32'd1);
    check("pend_off", 32'(int_pending_o), 32'd0);
    int_i = 0;

    // write masks
    raddr_i = 13;
    mtc0(13, 32'hFFFFFFFF);
    check("cause_sw_mask", cause_o & 32'h00000300, 32'h00000300);
    raddr_i = 12;
    mtc0(12, 32'hFFFFFFFF);
    check("status_mask", data_o, 32'hF000FF03);

    // BadVAddr
    raddr_i = 8;
    raise_exc(4, 32'h400, 0, 32'hDEAD0001);
`ifdef CP0_BADVADDR_EN
    check("badvaddr", data_o, 32'hDEAD0001);
`else
    check("badvaddr_off", data_o, 32'h0);
`endif

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      int_i = 6'($urandom);
      raddr_i = ($urandom_range(0, 3) == 0) ? 5'($urandom) : addr_tbl[$urandom_range(0, 8)];
      if ($urandom_range(0, 3) == 0) begin
        we_i = 1;
        waddr_i = addr_tbl[$urandom_range(0, 8)];
        data_i = $urandom;
        if (waddr_i == 11) data_i = m_count + $urandom_range(2, 30);
        if (waddr_i == 9 && $urandom_range(0, 1) == 1) data_i = m_compare - $urandom_range(1, 10);
      end
      exc_valid_i = ($urandom_range(0, 9) == 0);
      exc_code_i = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(4, 5)) : 5'($urandom);
      exc_pc_i = $urandom & 32'hFFFFFFFC;
      exc_bd_i = 1'($urandom);
      exc_badvaddr_i = $urandom;
      eret_i = ($urandom_range(0, 9) == 0);
      tick();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
